// File: rtl/mult_pkg.sv
// mult_pkg: FSM state encoding and accumulator width helper for mult_dot_acc
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int acc_width(input int m, input int n, input int len_w);
    return m + n + len_w;
  endfunction
endpackage

// File: rtl/mult_mnbit.sv
// mult_mnbit: combinational unsigned MxN multiplier (A, B in; product out, M+N bits)
module mult_mnbit #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic [M-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [M+N-1:0] product
);
  assign product = {{N{1'b0}}, A} * {{M{1'b0}}, B};
endmodule

// File: rtl/mult_dot_acc.sv
// mult_dot_acc: len-term unsigned dot product; start/len, in_valid/in_ready A,B stream, out_valid/out_ready acc, busy
module mult_dot_acc
  import mult_pkg::*;
#(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int LEN_W = 4,
  parameter int ACC_W = acc_width(M, N, LEN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     A,
  input  logic [N-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             busy
);
  state_t             state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;
  logic [M+N-1:0]     product;
  logic [M+N-1:0]     prod_q;
  logic               pv;
  logic               fire;
  mult_mnbit #(.M(M), .N(N)) u_mult (.A(A), .B(B), .product(product));
  assign fire      = in_valid && in_ready;
  assign in_ready  = state == RUN;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= '0;
      prod_q <= '0;
      pv     <= 1'b0;
      acc    <= '0;
    end else begin
      pv <= fire;
      if (fire) prod_q <= product;
      if (pv) acc <= acc + ACC_W'(prod_q);
      case (state)
        IDLE: if (start) begin
          len_q <= len;
          cnt   <= '0;
          acc   <= '0;
          state <= len == '0 ? DONE : RUN;
        end
        RUN: if (fire) begin
          cnt <= cnt + 1'b1;
          if (cnt + 1'b1 == len_q) state <= DRAIN;
        end
        DRAIN: if (!pv) state <= DONE;
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_dot_acc.sv
// tb_mult_dot_acc: table-driven and hand-sequenced checks of mult_dot_acc
module tb_mult_dot_acc;
  localparam int M = 4, N = 4, LEN_W = 4, ACC_W = 12;
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [M-1:0]     A;
  logic [N-1:0]     B;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic             busy;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int len;
    int a[15];
    int b[15];
    int exp;
  } vec_t;
  vec_t vt[5];
  mult_dot_acc #(.M(M), .N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .acc(acc), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    start = 1'b1;
    len = LEN_W'(v.len);
    tick();
    start = 1'b0;
    if (v.len == 0) begin
      chk({tag, " out_valid next cycle"}, int'(out_valid), 1);
      chk({tag, " acc"}, int'(acc), 0);
    end else begin
      for (int i = 0; i < v.len; i++) begin
        in_valid = 1'b1;
        A = M'(v.a[i]);
        B = N'(v.b[i]);
        if (!in_ready) begin
          errors++;
          checks++;
          $display("FAIL %s in_ready beat %0d: got 0 expected 1", tag, i);
        end
        tick();
      end
      in_valid = 1'b0;
      chk({tag, " in_ready after last"}, int'(in_ready), 0);
      tick();
      chk({tag, " out_valid at E+1"}, int'(out_valid), 0);
      tick();
      chk({tag, " out_valid at E+2"}, int'(out_valid), 1);
      chk({tag, " acc"}, int'(acc), v.exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " busy after handshake"}, int'(busy), 0);
    chk({tag, " acc retained"}, int'(acc), v.exp);
  endtask
  initial begin
    vt[0].len = 3; vt[0].exp = 39;
    vt[0].a[0] = 1; vt[0].b[0] = 6;
    vt[0].a[1] = 4; vt[0].b[1] = 2;
    vt[0].a[2] = 5; vt[0].b[2] = 5;
    vt[1].len = 15; vt[1].exp = 3375;
    for (int i = 0; i < 15; i++) begin
      vt[1].a[i] = 15;
      vt[1].b[i] = 15;
    end
    vt[2].len = 0; vt[2].exp = 0;
    vt[3].len = 2; vt[3].exp = 0;
    vt[3].a[0] = 0; vt[3].b[0] = 6;
    vt[3].a[1] = 0; vt[3].b[1] = 0;
    vt[4].len = 4; vt[4].exp = 52;
    vt[4].a[0] = 2;  vt[4].b[0] = 3;
    vt[4].a[1] = 3;  vt[4].b[1] = 3;
    vt[4].a[2] = 7;  vt[4].b[2] = 1;
    vt[4].a[3] = 15; vt[4].b[3] = 2;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    A = '0; B = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset acc", int'(acc), 0);
    in_valid = 1'b1; A = 4'd3; B = 4'd3;
    tick();
    in_valid = 1'b0;
    chk("idle ignores in_valid busy", int'(busy), 0);
    chk("idle ignores in_valid acc", int'(acc), 0);
    for (int k = 0; k < 5; k++) run_vec(vt[k], $sformatf("vec%0d", k));
    start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; A = 4'd4; B = 4'd2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall in_ready", int'(in_ready), 1);
      chk("stall out_valid", int'(out_valid), 0);
      tick();
    end
    chk("stall acc partial", int'(acc), 8);
    in_valid = 1'b1; A = 4'd5; B = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("backpressure out_valid", int'(out_valid), 1);
      chk("backpressure acc", int'(acc), 33);
      start = i == 2;
      len = 4'd1;
      tick();
    end
    start = 1'b0;
    chk("start in DONE ignored", int'(out_valid), 1);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("start at handshake ignored busy", int'(busy), 0);
    chk("post handshake acc", int'(acc), 33);
    tick();
    chk("still idle", int'(busy), 0);
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; A = 4'd2; B = 4'd2;
    tick();
    A = 4'd3; B = 4'd3;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst in_ready", int'(in_ready), 0);
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst acc", int'(acc), 0);
    chk("midrst busy", int'(busy), 0);
    tick();
    chk("midrst squashed acc", int'(acc), 0);
    vt[0].len = 1; vt[0].exp = 9;
    vt[0].a[0] = 3; vt[0].b[0] = 3;
    run_vec(vt[0], "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
